// File: rtl/led_status_seq_if.sv
// Status/LED signal bundle between fault sources, the sequencer and the LED mux.
// Latency: none (wires only).
// Backpressure: none; sources are level-sampled and the LED side is always shown.
// Ports: asserted_i/status_i/clr_i from sources, led_drive_o/led_data_o/busy_o/pend_o back.
interface led_status_seq_if #(
  parameter int N_CH   = 2,
  parameter int STAT_W = 97,
  parameter int LED_W  = 8
);
  logic [N_CH-1:0]        asserted_i;
  logic [N_CH*STAT_W-1:0] status_i;
  logic                   clr_i;
  logic                   led_drive_o;
  logic [LED_W-1:0]       led_data_o;
  logic                   busy_o;
  logic [N_CH-1:0]        pend_o;

  // master: fault sources / controller side, slave: the sequencer
  modport master (
    output asserted_i, status_i, clr_i,
    input  led_drive_o, led_data_o, busy_o, pend_o
  );
  modport slave (
    input  asserted_i, status_i, clr_i,
    output led_drive_o, led_data_o, busy_o, pend_o
  );
endinterface

// File: rtl/led_status_seq.sv
// Multi-channel status-to-LED sequencer: latches per-channel status and shows
// alert, header, one frame per set bit, then a gap, lowest pending channel first.
// Latency: pend after 1 edge, ALERT 1 edge later; frames held DWELL_CYC cycles.
// Backpressure: none; a pending channel ignores new asserts until it finishes.
// Ports: clk, resetn (sync, active-low), bus (led_status_seq_if.slave).
module led_status_seq #(
  parameter int N_CH      = 2,
  parameter int STAT_W    = 97,
  parameter int LED_W     = 8,
  parameter int DWELL_CYC = 125_000_000
) (
  input  logic            clk,
  input  logic            resetn,
  led_status_seq_if.slave bus
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int I_W   = (STAT_W > 1) ? $clog2(STAT_W) : 1;
  localparam int CNT_W = $clog2(DWELL_CYC + 1);
  localparam int FRM_W = LED_W - 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [I_W-1:0]   I_LAST   = I_W'(STAT_W - 1);

  typedef enum logic [2:0] {IDLE, ALERT, HEAD, SCAN, SHOW, GAP} state_t;

  state_t            state;
  logic [N_CH-1:0]   pend;
  logic [STAT_W-1:0] stat [N_CH];
  logic [CH_W-1:0]   cur;
  logic [I_W-1:0]    idx;
  logic [CNT_W-1:0]  cnt;
  logic              drive;
  logic [LED_W-1:0]  data;
  logic              busy;

  logic [CH_W-1:0]   sel;
  logic              any_pend;

  // Lowest-index pending channel: scan downwards so the last hit wins.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (pend[c]) begin
        sel      = CH_W'(c);
        any_pend = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      pend  <= '0;
      cur   <= '0;
      idx   <= '0;
      cnt   <= '0;
      drive <= 1'b0;
      data  <= '0;
      busy  <= 1'b0;
    end else if (bus.clr_i) begin
      // Abort wins over capture: nothing is latched on this edge.
      state <= IDLE;
      pend  <= '0;
      idx   <= '0;
      cnt   <= '0;
      drive <= 1'b0;
      data  <= '0;
      busy  <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.asserted_i[c] && !pend[c]) begin
          pend[c] <= 1'b1;
          stat[c] <= bus.status_i[c*STAT_W +: STAT_W];
        end
      end

      case (state)
        IDLE: begin
          if (any_pend) begin
            cur   <= sel;
            idx   <= '0;
            cnt   <= CNT_LOAD;
            state <= ALERT;
            busy  <= 1'b1;
            drive <= 1'b1;
            data  <= '1;
          end
        end
        ALERT: begin
          if (cnt == '0) begin
            cnt   <= CNT_LOAD;
            state <= HEAD;
            data  <= {1'b1, FRM_W'(cur)};
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HEAD: begin
          if (cnt == '0) state <= SCAN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        // SCAN leaves led_data untouched so the previous frame stays lit.
        SCAN: begin
          if (stat[cur][idx]) begin
            cnt   <= CNT_LOAD;
            state <= SHOW;
            data  <= {1'b0, FRM_W'(idx)};
          end else if (idx == I_LAST) begin
            cnt   <= CNT_LOAD;
            state <= GAP;
            drive <= 1'b0;
            data  <= '0;
          end else begin
            idx <= idx + I_W'(1);
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            if (idx == I_LAST) begin
              cnt   <= CNT_LOAD;
              state <= GAP;
              drive <= 1'b0;
              data  <= '0;
            end else begin
              idx   <= idx + I_W'(1);
              state <= SCAN;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            // Placed after the capture loop so the clear wins for this channel.
            pend[cur] <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          drive <= 1'b0;
          data  <= '0;
        end
      endcase
    end
  end

  assign bus.led_drive_o = drive;
  assign bus.led_data_o  = data;
  assign bus.busy_o      = busy;
  assign bus.pend_o      = pend;

endmodule

// File: tb/tb_led_status_seq.sv
// Bench for led_status_seq (N_CH=2, STAT_W=8, LED_W=8, DWELL_CYC=4).
// Latency: expected LED runs queued at stimulus time, matched by a run monitor.
// Backpressure: n/a; all waits on the DUT are cycle-bounded.
module tb_led_status_seq;

  localparam int N_CH = 2, STAT_W = 8, LED_W = 8, DWELL = 4;

  typedef struct {
    logic       drive;
    logic [7:0] data;
    logic       busy;
    int         len;
  } seg_t;

  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;
  seg_t exp_q[$];

  led_status_seq_if #(.N_CH(N_CH), .STAT_W(STAT_W), .LED_W(LED_W)) bus ();

  led_status_seq #(.N_CH(N_CH), .STAT_W(STAT_W), .LED_W(LED_W), .DWELL_CYC(DWELL)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic [7:0] v, input logic b, input int n);
    seg_t s;
    s.drive = d; s.data = v; s.busy = b; s.len = n;
    exp_q.push_back(s);
  endtask

  // Run monitor: collapses the output stream into constant (drive,data,busy) runs.
  logic [9:0] rkey;
  int         rlen = 0;
  bit         rvalid = 0;
  bit         started = 0;

  task automatic close_run(input logic [9:0] key, input int len);
    seg_t s;
    if (exp_q.size() == 0) begin
      if (key[0]) begin
        checks++; errors++;
        $display("FAIL unexpected_run: got drive=%0d data=%02h len=%0d with nothing queued",
                 key[9], key[8:1], len);
      end
    end else if (!(key[0] == 1'b0 && exp_q[0].busy == 1'b1)) begin
      s = exp_q.pop_front();
      checks++;
      if (key !== {s.drive, s.data, s.busy} || len != s.len) begin
        errors++;
        $display("FAIL run: got drive=%0d data=%02h busy=%0d len=%0d, want drive=%0d data=%02h busy=%0d len=%0d",
                 key[9], key[8:1], key[0], len, s.drive, s.data, s.busy, s.len);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] mkey;
    mkey = {bus.led_drive_o, bus.led_data_o, bus.busy_o};
    if (started && mkey == rkey) begin
      rlen++;
    end else begin
      if (started && rvalid) close_run(rkey, rlen);
      rkey    = mkey;
      rlen    = 1;
      rvalid  = mon_en;
      started = 1;
    end
    if (!mon_en) rvalid = 0;
  end

  task automatic wait_busy(input logic val, input int limit, input string name);
    int n = 0;
    while (bus.busy_o !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.busy_o, val);
  endtask

  task automatic wait_frame(input logic [7:0] v, input int limit, input string name);
    int n = 0;
    while (!(bus.led_drive_o === 1'b1 && bus.led_data_o === v) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.led_data_o, v);
  endtask

  task automatic pulse(input logic [1:0] ch, input logic [7:0] s0, input logic [7:0] s1);
    @(posedge clk); #1;
    bus.status_i   = {s1, s0};
    bus.asserted_i = ch;
    @(posedge clk); #1;
    bus.asserted_i = '0;
  endtask

  task automatic push_ch0_05();
    push(1, 8'hFF, 1, 4); push(1, 8'h80, 1, 5); push(1, 8'h00, 1, 6);
    push(1, 8'h02, 1, 9); push(0, 8'h00, 1, 4);
  endtask

  initial begin
    resetn         = 1'b0;
    bus.asserted_i = '0;
    bus.status_i   = '0;
    bus.clr_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_drive", bus.led_drive_o, 0);
    chk("reset_data",  bus.led_data_o, 0);
    chk("reset_busy",  bus.busy_o, 0);
    chk("reset_pend",  bus.pend_o, 0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1;

    // ch0 = 0x05, one-cycle assert; pend/ALERT latency checked directly
    push_ch0_05();
    @(posedge clk); #1;
    bus.status_i = 16'h0005; bus.asserted_i = 2'b01;
    @(posedge clk); #1 bus.asserted_i = '0;
    @(negedge clk);
    chk("t1_pend_latency", bus.pend_o, 2'b01);
    chk("t1_busy_still_idle", bus.busy_o, 0);
    @(negedge clk);
    chk("t1_alert_drive", bus.led_drive_o, 1);
    chk("t1_alert_data", bus.led_data_o, 8'hFF);
    wait_busy(0, 100, "t1_done");
    chk("t1_pend_cleared", bus.pend_o, 0);
    repeat (3) @(negedge clk);

    // both channels at once: ch0=0x01 then ch1=0x80 after one IDLE cycle
    push(1, 8'hFF, 1, 4); push(1, 8'h80, 1, 5); push(1, 8'h00, 1, 11); push(0, 8'h00, 1, 4);
    push(0, 8'h00, 0, 1);
    push(1, 8'hFF, 1, 4); push(1, 8'h81, 1, 12); push(1, 8'h07, 1, 4); push(0, 8'h00, 1, 4);
    pulse(2'b11, 8'h01, 8'h80);
    wait_busy(1, 10, "t2_start");
    wait_busy(0, 100, "t2_ch0_done");
    wait_busy(1, 10, "t2_ch1_start");
    wait_busy(0, 100, "t2_done");
    repeat (3) @(negedge clk);

    // ch1 all-zero status: no SHOW frame
    push(1, 8'hFF, 1, 4); push(1, 8'h81, 1, 12); push(0, 8'h00, 1, 4);
    pulse(2'b10, 8'h00, 8'h00);
    wait_busy(1, 10, "t3_start");
    wait_busy(0, 100, "t3_done");
    repeat (3) @(negedge clk);

    // new status and re-asserts while pending are ignored
    push_ch0_05();
    pulse(2'b01, 8'h05, 8'h00);
    repeat (6) @(negedge clk);
    bus.status_i = 16'h00FA; bus.asserted_i = 2'b01;
    @(negedge clk);
    bus.asserted_i = '0;
    repeat (5) @(negedge clk);
    bus.status_i = 16'h0033;
    chk("t4_pend_held", bus.pend_o, 2'b01);
    wait_busy(0, 100, "t4_done");
    repeat (3) @(negedge clk);

    // clr during SHOW
    mon_en = 0;
    pulse(2'b01, 8'h01, 8'h00);
    wait_frame(8'h00, 40, "t5_reach_show");
    bus.clr_i = 1'b1;
    @(negedge clk);
    bus.clr_i = 1'b0;
    chk("t5_clr_drive", bus.led_drive_o, 0);
    chk("t5_clr_data",  bus.led_data_o, 0);
    chk("t5_clr_pend",  bus.pend_o, 0);
    chk("t5_clr_busy",  bus.busy_o, 0);
    repeat (10) @(negedge clk);
    chk("t5_no_restart", bus.busy_o, 0);

    // reset during HEAD
    pulse(2'b10, 8'h00, 8'h03);
    wait_frame(8'h81, 40, "t5b_reach_head");
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5b_rst_drive", bus.led_drive_o, 0);
    chk("t5b_rst_data",  bus.led_data_o, 0);
    chk("t5b_rst_pend",  bus.pend_o, 0);
    chk("t5b_rst_busy",  bus.busy_o, 0);
    repeat (10) @(negedge clk);
    chk("t5b_no_restart", bus.busy_o, 0);
    mon_en = 1;
    repeat (2) @(negedge clk);

    // held assert re-arms with a fresh sample: 0x01 pass then 0x02 pass
    push(1, 8'hFF, 1, 4); push(1, 8'h80, 1, 5); push(1, 8'h00, 1, 11); push(0, 8'h00, 1, 4);
    push(0, 8'h00, 0, 2);
    push(1, 8'hFF, 1, 4); push(1, 8'h80, 1, 6); push(1, 8'h01, 1, 10); push(0, 8'h00, 1, 4);
    @(posedge clk); #1;
    bus.status_i = 16'h0001; bus.asserted_i = 2'b01;
    wait_busy(1, 10, "t6_start");
    repeat (10) @(negedge clk);
    bus.status_i = 16'h0002;
    wait_busy(0, 100, "t6_pass1_done");
    @(posedge clk); #1 bus.asserted_i = '0;
    wait_busy(1, 10, "t6_pass2_start");
    wait_busy(0, 100, "t6_done");
    repeat (3) @(negedge clk);
    chk("t6_pend_final", bus.pend_o, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
